// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring position monitor: FSM state encoding,
// direction constants and one-hot check/encode functions.
package ring_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } ring_state_e;

  localparam logic DIR_DEC = 1'b1;
  localparam logic DIR_INC = 1'b0;

  // Helpers operate on a fixed-width word; callers zero-extend narrower rings.
  localparam int RING_MAX_W = 64;
  localparam int RING_IDX_W = 6;

  function automatic logic onehot_ok(input logic [RING_MAX_W-1:0] word);
    int cnt;
    cnt = 0;
    for (int i = 0; i < RING_MAX_W; i++) begin
      if (word[i]) cnt++;
    end
    return (cnt == 1);
  endfunction

  // Index of the lowest set bit; zero for an all-zero word.
  function automatic logic [RING_IDX_W-1:0] onehot_enc(input logic [RING_MAX_W-1:0] word);
    logic [RING_IDX_W-1:0] idx;
    idx = '0;
    for (int i = RING_MAX_W - 1; i >= 0; i--) begin
      if (word[i]) idx = RING_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot check plus priority encoder for a WIDTH-bit ring word.
module ring_onehot_enc
  import ring_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int POS_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] word,
  output logic             legal,
  output logic [POS_W-1:0] index
);

  logic [RING_MAX_W-1:0] ext;

  always_comb begin
    ext              = '0;
    ext[WIDTH-1:0]   = word;
    legal            = onehot_ok(ext);
    index            = POS_W'(onehot_enc(ext));
  end

endmodule

// File: rtl/ring_pos_monitor.sv
// Ring counter integrity monitor: one-hot check, position encode, direction and
// revolution tracking. Define RING_POS_MONITOR_FAULTCNT_EN to add fault_cnt.
module ring_pos_monitor
  import ring_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int REV_W = 16,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             clr_err,
  output logic [POS_W-1:0] pos,
  output logic             pos_valid,
  output logic             dir,
  output logic             step,
  output logic [REV_W-1:0] rev_cnt,
  output logic             rev_pulse,
  output logic             err_onehot,
  output logic             err_jump
`ifdef RING_POS_MONITOR_FAULTCNT_EN
  ,
  output logic [7:0]       fault_cnt
`endif
);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);
  localparam logic [POS_W:0]   ACC_WRAP = (POS_W + 1)'(WIDTH);

  ring_state_e      state, state_nxt;
  logic [POS_W-1:0] acc, acc_nxt;
  logic [POS_W-1:0] pos_nxt;
  logic             pos_valid_nxt, dir_nxt, step_nxt, rev_pulse_nxt;
  logic [REV_W-1:0] rev_cnt_nxt;
  logic             err_onehot_nxt, err_jump_nxt;

  logic             legal;
  logic [POS_W-1:0] idx;
  logic [POS_W-1:0] pm1, pp1;
  logic             new_dir;
  logic [POS_W:0]   acc_sum;

  ring_onehot_enc #(.WIDTH(WIDTH), .POS_W(POS_W)) u_enc (
    .word  (ring_in),
    .legal (legal),
    .index (idx)
  );

  always_comb begin
    pm1     = (pos == '0) ? POS_LAST : pos - 1'b1;
    pp1     = (pos == POS_LAST) ? '0 : pos + 1'b1;
    new_dir = (idx == pm1) ? DIR_DEC : DIR_INC;
    // A reversal restarts the count at 1; acc==0 (fresh or just wrapped) just counts on.
    acc_sum = ((new_dir != dir) && (acc != '0)) ? (POS_W + 1)'(1) : {1'b0, acc} + 1'b1;

    state_nxt      = state;
    acc_nxt        = acc;
    pos_nxt        = pos;
    pos_valid_nxt  = pos_valid;
    dir_nxt        = dir;
    step_nxt       = 1'b0;
    rev_cnt_nxt    = rev_cnt;
    rev_pulse_nxt  = 1'b0;
    err_onehot_nxt = err_onehot;
    err_jump_nxt   = err_jump;

    if (clr_err) begin
      err_onehot_nxt = 1'b0;
      err_jump_nxt   = 1'b0;
      state_nxt      = IDLE;
      pos_valid_nxt  = 1'b0;
      acc_nxt        = '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (legal) begin
            pos_nxt       = idx;
            pos_valid_nxt = 1'b1;
            acc_nxt       = '0;
            state_nxt     = TRACK;
          end else begin
            err_onehot_nxt = 1'b1;
            state_nxt      = FAULT;
          end
        end
        TRACK: begin
          if (!legal) begin
            err_onehot_nxt = 1'b1;
            pos_valid_nxt  = 1'b0;
            state_nxt      = FAULT;
          end else if (idx == pos) begin
            step_nxt = 1'b0;
          end else if ((idx == pm1) || (idx == pp1)) begin
            step_nxt = 1'b1;
            pos_nxt  = idx;
            dir_nxt  = new_dir;
            if (acc_sum == ACC_WRAP) begin
              acc_nxt       = '0;
              rev_cnt_nxt   = rev_cnt + 1'b1;
              rev_pulse_nxt = 1'b1;
            end else begin
              acc_nxt = acc_sum[POS_W-1:0];
            end
          end else begin
            err_jump_nxt  = 1'b1;
            pos_valid_nxt = 1'b0;
            state_nxt     = FAULT;
          end
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      acc        <= '0;
      pos        <= '0;
      pos_valid  <= 1'b0;
      dir        <= 1'b0;
      step       <= 1'b0;
      rev_cnt    <= '0;
      rev_pulse  <= 1'b0;
      err_onehot <= 1'b0;
      err_jump   <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      pos        <= pos_nxt;
      pos_valid  <= pos_valid_nxt;
      dir        <= dir_nxt;
      step       <= step_nxt;
      rev_cnt    <= rev_cnt_nxt;
      rev_pulse  <= rev_pulse_nxt;
      err_onehot <= err_onehot_nxt;
      err_jump   <= err_jump_nxt;
    end
  end

`ifdef RING_POS_MONITOR_FAULTCNT_EN
  // Counts entries into FAULT; survives clr_err so repeated faults stay visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_cnt <= '0;
    end else if ((state != FAULT) && (state_nxt == FAULT) && (fault_cnt != 8'hFF)) begin
      fault_cnt <= fault_cnt + 1'b1;
    end
  end
`else
  // No fault counter in this build.
`endif

endmodule

// File: tb/tb_ring_pos_monitor.sv
// Self-checking bench for ring_pos_monitor: vector table, hand sequences for
// revolution/async reset, and a random walk checked against a small model.
module tb_ring_pos_monitor;

  localparam int OW = 25;

  logic        clk = 1'b0;
  logic        rst, en, clr_err;
  logic [7:0]  ring_in;
  logic [2:0]  pos;
  logic        pos_valid, dir, step, rev_pulse, err_onehot, err_jump;
  logic [15:0] rev_cnt;
`ifdef RING_POS_MONITOR_FAULTCNT_EN
  logic [7:0]  fault_cnt;
`endif

  ring_pos_monitor #(.WIDTH(8), .REV_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ring_in    (ring_in),
    .clr_err    (clr_err),
    .pos        (pos),
    .pos_valid  (pos_valid),
    .dir        (dir),
    .step       (step),
    .rev_cnt    (rev_cnt),
    .rev_pulse  (rev_pulse),
    .err_onehot (err_onehot),
    .err_jump   (err_jump)
`ifdef RING_POS_MONITOR_FAULTCNT_EN
    ,
    .fault_cnt  (fault_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic          clr;
    logic [7:0]    ring;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t          tbl[$];
  logic [OW-1:0] exp_q[$];
  int            total = 0;
  int            bad = 0;

  int            m_pos, m_acc, m_rev;
  bit            m_dir;

  function automatic logic [OW-1:0] pk(int p, bit pv, bit d, bit s, int rev, bit rp, bit eo, bit ej);
    return {3'(p), pv, d, s, 16'(rev), rp, eo, ej};
  endfunction

  function automatic vec_t v(bit e, bit c, logic [7:0] r, logic [OW-1:0] x);
    vec_t t;
    t.en   = e;
    t.clr  = c;
    t.ring = r;
    t.exp  = x;
    return t;
  endfunction

  task automatic check(input string name);
    logic [OW-1:0] act, want;
    act  = {pos, pos_valid, dir, step, rev_cnt, rev_pulse, err_onehot, err_jump};
    want = exp_q.pop_front();
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (pos,pv,dir,step,rev,rp,eo,ej)", name, act, want);
    end
  endtask

  task automatic apply(input bit e, input bit c, input logic [7:0] r,
                       input logic [OW-1:0] x, input string name);
    @(negedge clk);
    en      = e;
    clr_err = c;
    ring_in = r;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; clr_err = 1'b0; ring_in = 8'h00;

    // en, clr, ring -> pos, pos_valid, dir, step, rev_cnt, rev_pulse, err_onehot, err_jump
    tbl.push_back(v(1, 0, 8'h01, pk(0, 1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h80, pk(7, 1, 1, 1, 0, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h40, pk(6, 1, 1, 1, 0, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h20, pk(5, 1, 1, 1, 0, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h10, pk(4, 1, 1, 1, 0, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h08, pk(3, 1, 1, 1, 0, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h04, pk(2, 1, 1, 1, 0, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h02, pk(1, 1, 1, 1, 0, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h01, pk(0, 1, 1, 1, 1, 1, 0, 0)));
    tbl.push_back(v(0, 0, 8'h80, pk(0, 1, 1, 0, 1, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h01, pk(0, 1, 1, 0, 1, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h02, pk(1, 1, 0, 1, 1, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h04, pk(2, 1, 0, 1, 1, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h02, pk(1, 1, 1, 1, 1, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h04, pk(2, 1, 0, 1, 1, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h20, pk(2, 0, 0, 0, 1, 0, 0, 1)));
    tbl.push_back(v(1, 0, 8'h01, pk(2, 0, 0, 0, 1, 0, 0, 1)));
    tbl.push_back(v(1, 0, 8'h00, pk(2, 0, 0, 0, 1, 0, 0, 1)));
    tbl.push_back(v(1, 1, 8'h01, pk(2, 0, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(v(0, 0, 8'h01, pk(2, 0, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h00, pk(2, 0, 0, 0, 1, 0, 1, 0)));
    tbl.push_back(v(1, 0, 8'h81, pk(2, 0, 0, 0, 1, 0, 1, 0)));
    tbl.push_back(v(0, 1, 8'h00, pk(2, 0, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h81, pk(2, 0, 0, 0, 1, 0, 1, 0)));
    tbl.push_back(v(1, 1, 8'h10, pk(2, 0, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h10, pk(4, 1, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h08, pk(3, 1, 1, 1, 1, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h04, pk(2, 1, 1, 1, 1, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h0C, pk(2, 0, 1, 0, 1, 0, 1, 0)));
    tbl.push_back(v(0, 1, 8'h00, pk(2, 0, 1, 0, 1, 0, 0, 0)));
    tbl.push_back(v(1, 0, 8'h01, pk(0, 1, 1, 0, 1, 0, 0, 0)));
    tbl.push_back(v(1, 1, 8'h02, pk(0, 0, 1, 0, 1, 0, 0, 0)));

    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0));
    check("reset");
    @(negedge clk) rst = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].en, tbl[i].clr, tbl[i].ring, tbl[i].exp, $sformatf("row%0d", i));
    end

`ifdef RING_POS_MONITOR_FAULTCNT_EN
    total++;
    if (fault_cnt !== 8'd4) begin
      bad++;
      $display("FAIL fault_cnt got=%0d want=4", fault_cnt);
    end
`endif

    // Fresh start, three full increment revolutions plus five steps (acc=5, rev_cnt=3).
    @(negedge clk);
    en = 1'b0; clr_err = 1'b0; rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    apply(1, 0, 8'h01, pk(0, 1, 0, 0, 0, 0, 0, 0), "rev_start");
    for (int k = 1; k <= 29; k++) begin
      apply(1, 0, 8'h01 << (k % 8), pk(k % 8, 1, 0, 1, k / 8, (k % 8) == 0, 0, 0),
            $sformatf("rev_step%0d", k));
    end

    // Asynchronous reset between clock edges.
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b0;
    #1;
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0));
    check("async_rst");
`ifdef RING_POS_MONITOR_FAULTCNT_EN
    total++;
    if (fault_cnt !== 8'd0) begin
      bad++;
      $display("FAIL fault_cnt_rst got=%0d want=0", fault_cnt);
    end
`endif
    @(negedge clk) rst = 1'b1;
    apply(1, 0, 8'h10, pk(4, 1, 0, 0, 0, 0, 0, 0), "post_rst");

    // Random walk of legal moves, biased toward incrementing.
    m_pos = 4; m_acc = 0; m_rev = 0; m_dir = 1'b0;
    for (int k = 0; k < 200; k++) begin
      bit         e, st, rp, nd;
      int         sel, n;
      logic [7:0] word;
      e   = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      n   = (sel < 2) ? m_pos : (sel < 8) ? (m_pos + 1) % 8 : (m_pos + 7) % 8;
      st  = 1'b0;
      rp  = 1'b0;
      if (e) word = 8'h01 << n;
      else   word = 8'($urandom_range(0, 255));
      if (e && (n != m_pos)) begin
        nd = (sel >= 8);
        if ((nd != m_dir) && (m_acc != 0)) m_acc = 1;
        else m_acc = m_acc + 1;
        if (m_acc == 8) begin
          m_acc = 0;
          m_rev = m_rev + 1;
          rp    = 1'b1;
        end
        m_dir = nd;
        m_pos = n;
        st    = 1'b1;
      end
      apply(e, 0, word, pk(m_pos, 1, m_dir, st, m_rev, rp, 0, 0), $sformatf("walk%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ring_pos_monitor.md
Name: ring_pos_monitor

Overview:
- Sits directly downstream of the 8-bit rotating ring counter.
- Samples the ring word, checks that it is one-hot, and encodes the bit position.
- Infers the rotation direction from successive samples and counts completed revolutions.
- Flags illegal patterns and illegal jumps with sticky error bits, so control logic can verify ring integrity and track position without decoding the ring itself.

Parameters:
- WIDTH, 8, ring width in bits; legal range >= 3.
- REV_W, 16, width of the revolution counter.
- POS_W, localparam = $clog2(WIDTH), width of the encoded position.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample strobe; ring_in is evaluated only when en=1.
- ring_in  input  WIDTH  ring counter word.
- clr_err  input  1  synchronous clear of sticky errors and the FAULT state.
- pos  output  POS_W  index of the set bit in the last accepted sample.
- pos_valid  output  1  pos is trustworthy (state TRACK).
- dir  output  1  direction of the last step: 1 = index decremented (ring rotating toward bit 0), 0 = incremented.
- step  output  1  one-cycle pulse when an accepted sample moved by exactly one position.
- rev_cnt  output  REV_W  completed revolutions; wraps modulo 2^REV_W.
- rev_pulse  output  1  one-cycle pulse when rev_cnt increments.
- err_onehot  output  1  sticky: a sample was zero or multi-hot.
- err_jump  output  1  sticky: a one-hot sample moved by more than one position.

Behaviour:
- Reset (rst=0, async) sets state=IDLE. All outputs go to 0: pos, pos_valid, dir, step, rev_cnt, rev_pulse, err_onehot, err_jump. The internal step accumulator acc is also cleared.
- All outputs are registered. The response to a sample at edge N is visible after edge N. Latency is 1 cycle.
- step and rev_pulse default to 0 every cycle.
- One-hot check: exactly one bit set. All-zero and multi-hot words are both illegal.
- clr_err=1 has priority over en. It clears err_onehot and err_jump, sets state=IDLE, pos_valid=0 and acc=0, and discards any simultaneous sample. rev_cnt and pos are retained.
- State IDLE (no reference sample), on en=1:
  - legal word: pos <= encoded index, pos_valid <= 1, acc <= 0, state -> TRACK.
  - illegal word: err_onehot <= 1, state -> FAULT.
- State TRACK, on en=1, with p = pos and n = index of ring_in:
  - illegal word: err_onehot <= 1, pos_valid <= 0, state -> FAULT.
  - n == p: hold; no step, acc unchanged.
  - n == (p-1) mod WIDTH: step <= 1, pos <= n. Set new dir=1.
  - n == (p+1) mod WIDTH: step <= 1, pos <= n. Set new dir=0.
  - any other n: err_jump <= 1, pos_valid <= 0, state -> FAULT. pos is not updated.
- Revolution counting on each step:
  - If new dir != previous dir and acc != 0, then acc <= 1 (a direction reversal restarts the count).
  - Otherwise acc <= acc+1.
  - When acc+1 == WIDTH: acc <= 0, rev_cnt <= rev_cnt+1, rev_pulse <= 1.
  - The first step after IDLE always counts as acc=1, whatever its direction.
- Wrap-around: position WIDTH-1 -> 0 is an increment and 0 -> WIDTH-1 is a decrement. Both are legal single steps.
- State FAULT: en is ignored, pos_valid=0. The block stays in FAULT until clr_err.
- en=0: no state change in any state.

Optional Feature:
- Macro RING_POS_MONITOR_FAULTCNT_EN.
- When defined:
  - Adds output port fault_cnt[7:0].
  - fault_cnt increments on every transition into FAULT and saturates at 255.
  - It is cleared only by rst, not by clr_err.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package ring_pkg holds:
  - state typedef for IDLE/TRACK/FAULT as a 2-bit encoding: IDLE=2'd0, TRACK=2'd1, FAULT=2'd2;
  - constants DIR_DEC=1'b1 and DIR_INC=1'b0;
  - function onehot_ok(word);
  - function onehot_enc(word).
- One natural sub-module: ring_onehot_enc, a combinational WIDTH-bit one-hot check plus priority encoder producing {legal, index}, instantiated once.

Test Plan:
- Reset, then en=1 with ring_in=8'h01 -> pos=0, pos_valid=1, step=0, rev_cnt=0.
- Start at 8'h01, then feed 8'h80, 8'h40 … 8'h01 (8 decrement steps) -> each step pulses with dir=1. On the 8th step rev_pulse=1 and rev_cnt=1. The 7->0 / 0->7 wrap is accepted.
- Feed 8'h01, 8'h02, 8'h04, then 8'h02 (direction reversal) -> dir goes 0,0,1. acc restarts at 1 and no rev_pulse.
- In TRACK at pos=2, feed 8'h20 -> err_jump=1, pos_valid=0, pos stays 2. Later en samples are ignored until clr_err=1, which gives IDLE with err_jump=0.
- Feed 8'h00, then 8'h81 -> err_onehot=1 and FAULT on the first. With RING_POS_MONITOR_FAULTCNT_EN, fault_cnt=1 and it stays 1 after clr_err.
- Assert rst low mid-revolution (acc=5, rev_cnt=3) -> all outputs 0 asynchronously. After release, 8'h10 gives pos=4 and no rev_pulse.
